// File: rtl/pulse_stretcher_mc_if.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_mc_if
// Bundles the data/control/status signals of pulse_stretcher_mc.
//   master : drives pulse_in, (edge_sel), stretch_len, retrig_en, clr_stat;
//            observes stretch_out, busy, pulse_count, overrun
//   slave  : the stretcher itself
// Optional: PULSE_STRETCH_FALL_EN adds the per-channel edge_sel signal.
// -----------------------------------------------------------------------------
interface pulse_stretcher_mc_if #(
    parameter int NCH   = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
);
    logic [NCH-1:0]       pulse_in;
`ifdef PULSE_STRETCH_FALL_EN
    logic [NCH-1:0]       edge_sel;
`endif
    logic [LEN_W-1:0]     stretch_len;
    logic                 retrig_en;
    logic                 clr_stat;
    logic [NCH-1:0]       stretch_out;
    logic                 busy;
    logic [NCH*CNT_W-1:0] pulse_count;
    logic [NCH-1:0]       overrun;

    modport master (
`ifdef PULSE_STRETCH_FALL_EN
        output edge_sel,
`endif
        output pulse_in, stretch_len, retrig_en, clr_stat,
        input  stretch_out, busy, pulse_count, overrun
    );

    modport slave (
`ifdef PULSE_STRETCH_FALL_EN
        input  edge_sel,
`endif
        input  pulse_in, stretch_len, retrig_en, clr_stat,
        output stretch_out, busy, pulse_count, overrun
    );
endinterface

// File: rtl/pulse_stretcher_mc.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_mc
// Multi-channel pulse stretcher: each asynchronous pulse input is synchronised,
// edge-detected and stretched into a high pulse of max(stretch_len,1) cycles.
// Per-channel saturating trigger counters and sticky overrun (dropped-edge)
// flags are provided for status.
//
// Ports:
//   clk   : single clock
//   reset : asynchronous active-high reset
//   bus   : pulse_stretcher_mc_if.slave
//           pulse_in[NCH], stretch_len[LEN_W], retrig_en, clr_stat  (in)
//           stretch_out[NCH], busy, pulse_count[NCH*CNT_W], overrun  (out)
//           channel i count occupies pulse_count[i*CNT_W +: CNT_W]
//
// Optional: define PULSE_STRETCH_FALL_EN to enable bus.edge_sel, which selects
// a falling-edge trigger per channel when set. Default build: rising only.
// The interface parameters must match the module parameters.
//
// Channel FSM:
//   state     | meaning
//   S_IDLE    | output low, waiting for an edge
//   S_STRETCH | output high, rem further cycles left after this one
// -----------------------------------------------------------------------------
module pulse_stretcher_mc #(
    parameter int NCH         = 4,
    parameter int LEN_W       = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               reset,
    pulse_stretcher_mc_if.slave bus
);

    typedef enum logic {S_IDLE, S_STRETCH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
    logic [NCH-1:0]                  hist_q, hist_d;
    logic [NCH-1:0]                  sync_last;
    logic [NCH-1:0]                  edge_det;

    state_t           state_q   [NCH];
    state_t           state_d   [NCH];
    logic [LEN_W-1:0] rem_q     [NCH];
    logic [LEN_W-1:0] rem_d     [NCH];
    logic [CNT_W-1:0] cnt_q     [NCH];
    logic [CNT_W-1:0] cnt_d     [NCH];
    logic [NCH-1:0]   overrun_q, overrun_d;
    logic [NCH-1:0]   stretch_d;
    logic             busy_q, busy_d;
    logic [NCH-1:0]   accept;
    logic [NCH-1:0]   drop;
    logic [LEN_W-1:0] len_load;

    // Synchroniser chain followed by one history flop for edge detection.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], bus.pulse_in};
        sync_last = sync_q[SYNC_STAGES-1];
        hist_d    = sync_last;
`ifdef PULSE_STRETCH_FALL_EN
        edge_det  = (sync_last & ~hist_q & ~bus.edge_sel) |
                    (~sync_last & hist_q & bus.edge_sel);
`else
        edge_det  = sync_last & ~hist_q;
`endif
    end

    // A length of 0 behaves like 1; rem counts cycles remaining after the
    // current one, so the load value is L-1.
    always_comb begin
        len_load = (bus.stretch_len == '0) ? '0 : bus.stretch_len - LEN_W'(1);
    end

    always_comb begin
        accept    = '0;
        drop      = '0;
        overrun_d = overrun_q;
        stretch_d = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (edge_det[i]) begin
                        state_d[i] = S_STRETCH;
                        rem_d[i]   = len_load;
                        accept[i]  = 1'b1;
                    end
                end
                default: begin
                    if (rem_q[i] == '0) begin
                        // Edge in the final cycle chains a new stretch
                        // regardless of retrig_en.
                        if (edge_det[i]) begin
                            rem_d[i]  = len_load;
                            accept[i] = 1'b1;
                        end else begin
                            state_d[i] = S_IDLE;
                        end
                    end else if (edge_det[i] && bus.retrig_en) begin
                        rem_d[i]  = len_load;
                        accept[i] = 1'b1;
                    end else begin
                        rem_d[i] = rem_q[i] - LEN_W'(1);
                        drop[i]  = edge_det[i];
                    end
                end
            endcase

            // Clearing wins over a same-cycle increment or overrun set.
            if (bus.clr_stat) begin
                cnt_d[i]     = '0;
                overrun_d[i] = 1'b0;
            end else begin
                if (accept[i] && cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                if (drop[i]) begin
                    overrun_d[i] = 1'b1;
                end
            end
            stretch_d[i] = (state_d[i] == S_STRETCH);
        end
        busy_d = |stretch_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            hist_q    <= '0;
            overrun_q <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
                rem_q[i]   <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        bus.stretch_out = '0;
        bus.pulse_count = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.stretch_out[i]                  = (state_q[i] == S_STRETCH);
            bus.pulse_count[i*CNT_W +: CNT_W]   = cnt_q[i];
        end
        bus.busy    = busy_q;
        bus.overrun = overrun_q;
    end

endmodule

// File: tb/tb_pulse_stretcher_mc.sv
module tb_pulse_stretcher_mc;
    localparam int NCH   = 4;
    localparam int LEN_W = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pulse_stretcher_mc_if #(.NCH(NCH), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus();

    pulse_stretcher_mc #(.NCH(NCH), .LEN_W(LEN_W), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per channel, number of high cycles still owed.
    int             left     [NCH];
    int             cnt      [NCH];
    bit             ovr      [NCH];
    logic [NCH-1:0] smp      [3];   // input samples from 1, 2, 3 edges ago
    int             run      [NCH];
    int             last_run [NCH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) smp[i] = '0;
        for (int i = 0; i < NCH; i++) begin
            left[i] = 0; cnt[i] = 0; ovr[i] = 0; run[i] = 0;
        end
    endtask

    // Called at a clock edge with the inputs that the DUT samples there.
    task automatic model_step();
        int  len;
        bit  e;
        bit  acc;
        bit  drp;
        len = (bus.stretch_len == 0) ? 1 : int'(bus.stretch_len);
        for (int i = 0; i < NCH; i++) begin
`ifdef PULSE_STRETCH_FALL_EN
            e = bus.edge_sel[i] ? (!smp[1][i] && smp[2][i]) : (smp[1][i] && !smp[2][i]);
`else
            e = smp[1][i] && !smp[2][i];
`endif
            acc = 0; drp = 0;
            if (e) begin
                if (left[i] <= 1 || bus.retrig_en) begin
                    left[i] = len; acc = 1;
                end else begin
                    left[i]--; drp = 1;
                end
            end else if (left[i] > 0) begin
                left[i]--;
            end
            if (bus.clr_stat) begin
                cnt[i] = 0; ovr[i] = 0;
            end else begin
                if (acc && cnt[i] < CMAX) cnt[i]++;
                if (drp) ovr[i] = 1;
            end
        end
        smp[2] = smp[1];
        smp[1] = smp[0];
        smp[0] = bus.pulse_in;
    endtask

    task automatic compare_all();
        logic [NCH-1:0]       es;
        logic [NCH-1:0]       eo;
        logic [NCH*CNT_W-1:0] ec;
        for (int i = 0; i < NCH; i++) begin
            es[i] = (left[i] > 0);
            eo[i] = ovr[i];
            ec[i*CNT_W +: CNT_W] = CNT_W'(cnt[i]);
            if (bus.stretch_out[i]) run[i]++;
            else if (run[i] > 0) begin
                last_run[i] = run[i];
                run[i] = 0;
            end
        end
        chk("stretch_out", 64'(bus.stretch_out), 64'(es));
        chk("busy",        64'(bus.busy),        64'(|es));
        chk("pulse_count", 64'(bus.pulse_count), 64'(ec));
        chk("overrun",     64'(bus.overrun),     64'(eo));
    endtask

    task automatic step(input logic [NCH-1:0] pin);
        @(negedge clk);
        bus.pulse_in = pin;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0);
    endtask

    function automatic logic [63:0] cnt_of(input int ch);
        return 64'(bus.pulse_count[ch*CNT_W +: CNT_W]);
    endfunction

    initial begin
        reset           = 1'b1;
        bus.pulse_in    = '0;
`ifdef PULSE_STRETCH_FALL_EN
        bus.edge_sel    = '0;
`endif
        bus.stretch_len = 8'd5;
        bus.retrig_en   = 1'b0;
        bus.clr_stat    = 1'b0;
        model_reset();
        for (int i = 0; i < NCH; i++) last_run[i] = 0;
        #12;
        chk("rst_stretch", 64'(bus.stretch_out), 64'(0));
        chk("rst_busy",    64'(bus.busy),        64'(0));
        chk("rst_count",   64'(bus.pulse_count), 64'(0));
        chk("rst_overrun", 64'(bus.overrun),     64'(0));
        @(posedge clk); #2 reset = 1'b0;

        // 1: single pulse, length 5
        step(4'b0001); idle(10);
        chk("t1_len", 64'(last_run[0]), 64'(5));
        chk("t1_cnt", cnt_of(0), 64'(1));

        // 2: length 0 behaves like 1
        bus.stretch_len = 8'd0;
        step(4'b0010); idle(5);
        chk("t2_len", 64'(last_run[1]), 64'(1));
        chk("t2_cnt", cnt_of(1), 64'(1));

        // 3: retrigger 3 cycles into an 8-cycle stretch
        bus.stretch_len = 8'd8; bus.retrig_en = 1'b1;
        step(4'b0100); idle(2); step(4'b0100); idle(15);
        chk("t3_len", 64'(last_run[2]), 64'(11));
        chk("t3_cnt", cnt_of(2), 64'(2));
        chk("t3_ovr", 64'(bus.overrun[2]), 64'(0));

        // 4: same with retrigger disabled, then a back-to-back chain
        bus.retrig_en = 1'b0;
        step(4'b1000); idle(2); step(4'b1000); idle(15);
        chk("t4_len", 64'(last_run[3]), 64'(8));
        chk("t4_cnt", cnt_of(3), 64'(1));
        chk("t4_ovr", 64'(bus.overrun[3]), 64'(1));
        bus.clr_stat = 1'b1; step('0); bus.clr_stat = 1'b0;
        step(4'b1000); idle(7); step(4'b1000); idle(20);
        chk("t4_b2b_len", 64'(last_run[3]), 64'(16));
        chk("t4_b2b_cnt", cnt_of(3), 64'(2));

        // 5: saturation, then clear coinciding with a trigger
        bus.stretch_len = 8'd1;
        for (int k = 0; k < 17; k++) begin
            step(4'b0001); idle(2);
        end
        chk("t5_sat", cnt_of(0), 64'(CMAX));
        bus.stretch_len = 8'd4;
        step(4'b0001); step('0);
        bus.clr_stat = 1'b1; step('0); bus.clr_stat = 1'b0;
        idle(6);
        chk("t5_clr_cnt", cnt_of(0), 64'(0));
        chk("t5_clr_ovr", 64'(bus.overrun[0]), 64'(0));
        chk("t5_clr_len", 64'(last_run[0]), 64'(4));

        // 6: reset mid-stretch, input held high through deassertion
        bus.stretch_len = 8'd10;
        step(4'b0010); idle(4);
        #2 reset = 1'b1;
        #1;
        chk("t6_stretch", 64'(bus.stretch_out), 64'(0));
        chk("t6_busy",    64'(bus.busy),        64'(0));
        chk("t6_count",   64'(bus.pulse_count), 64'(0));
        chk("t6_overrun", 64'(bus.overrun),     64'(0));
        model_reset();
        bus.pulse_in = 4'b1111;
        @(posedge clk); @(posedge clk); #2 reset = 1'b0;
        for (int k = 0; k < 16; k++) step(4'b1111);
        chk("t6_once_cnt", 64'(bus.pulse_count), 64'({NCH{4'd1}}));
        chk("t6_once_len", 64'(last_run[2]), 64'(10));
        idle(4);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            logic [NCH-1:0] pin;
            for (int i = 0; i < NCH; i++) pin[i] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) bus.stretch_len = LEN_W'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) bus.retrig_en = 1'($urandom_range(0, 1));
            bus.clr_stat = ($urandom_range(0, 24) == 0);
            step(pin);
        end
        bus.clr_stat = 1'b0;
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
